// File: rtl/soc_mem_pkg.sv
// Shared constants and sizing helpers for the round-robin shared RAM.
package soc_mem_pkg;

  localparam int BYTE_W = 8;

  localparam logic [31:0] DEF_FLAG_ADDR   = 32'h0000_0FF8;
  localparam logic [31:0] DEF_RESULT_ADDR = 32'h0000_0FFC;

  // Number of byte lanes in a data word.
  function automatic int be_width(input int dw);
    return dw / BYTE_W;
  endfunction

  // Word-index width for a RAM of the given depth (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/soc_mem_arbiter_rr_if.sv
// Core-side req/gnt/rvalid bus for all ports, packed per port.
interface soc_mem_arbiter_rr_if
  import soc_mem_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32
);
  localparam int BEW = be_width(DATA_WIDTH);

  logic [NUM_PORTS-1:0]                 req_i;
  logic [NUM_PORTS-1:0][31:0]           addr_i;
  logic [NUM_PORTS-1:0]                 we_i;
  logic [NUM_PORTS-1:0][BEW-1:0]        be_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS-1:0]                 gnt_o;
  logic [NUM_PORTS-1:0]                 rvalid_o;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o;

  // Core side drives requests and consumes responses.
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  // Memory side consumes requests and drives responses.
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with a registered last-granted pointer.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  if (N == 1) begin : g_single
    // A single port is a straight wire; no pointer is needed.
    assign gnt     = rst_i ? 1'b0 : req;
    assign gnt_idx = '0;
  end else begin : g_multi
    logic [IW-1:0] last_q;
    logic [IW-1:0] cand;
    logic          found;

    // Scan from last_q+1 upward with wrap; first pending request wins.
    always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 1; i <= N; i++) begin
        cand = IW'((int'(last_q) + i) % N);
        if (!found && req[cand]) begin
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
          found     = 1'b1;
        end
      end
      if (rst_i) gnt = '0;
    end

    // Pointer follows the winner; reset value makes port 0 highest priority.
    always_ff @(posedge clk_i) begin
      if (rst_i)     last_q <= IW'(N - 1);
      else if (found) last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/soc_mem_arbiter_rr.sv
// N-port round-robin shared single-port RAM with flag/result mirrors.
module soc_mem_arbiter_rr
  import soc_mem_pkg::*;
#(
  parameter int          NUM_PORTS   = 2,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] FLAG_ADDR   = DEF_FLAG_ADDR,
  parameter logic [31:0] RESULT_ADDR = DEF_RESULT_ADDR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  soc_mem_arbiter_rr_if.slave   bus,
  output logic [DATA_WIDTH-1:0] mem_flag_o,
  output logic [DATA_WIDTH-1:0] mem_result_o,
  output logic [15:0]           conflict_cnt_o
);

  localparam int BEW = be_width(DATA_WIDTH);
  localparam int IW  = idx_width(DEPTH_WORDS);
  localparam int GW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [NUM_PORTS-1:0]                 gnt;
  logic [GW-1:0]                        gnt_idx;
  logic                                 any_gnt;
  logic [31:0]                          s_addr;
  logic                                 s_we;
  logic [BEW-1:0]                       s_be;
  logic [DATA_WIDTH-1:0]                s_wdata;
  logic [IW-1:0]                        widx;
  logic                                 s_wr;
  logic [NUM_PORTS-1:0]                 rvalid_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_q;

  // Replace only the enabled byte lanes of old_w with new_w.
  function automatic logic [DATA_WIDTH-1:0] merge_be(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BEW-1:0]        be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < BEW; b++)
      if (be[b]) r[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
    return r;
  endfunction

  rr_arbiter #(.N(NUM_PORTS), .IW(GW)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (bus.req_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.gnt_o = gnt;
  assign any_gnt   = |gnt;

  // Winner's request fields; upper address bits fold onto the RAM size.
  assign s_addr  = bus.addr_i[gnt_idx];
  assign s_we    = bus.we_i[gnt_idx];
  assign s_be    = bus.be_i[gnt_idx];
  assign s_wdata = bus.wdata_i[gnt_idx];
  assign widx    = s_addr[IW+1:2];
  assign s_wr    = any_gnt && s_we;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (s_wr) mem[widx] <= merge_be(mem[widx], s_wdata, s_be);
  end

  // One-cycle response stage: every grant yields rvalid; only reads carry data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt;
      for (int k = 0; k < NUM_PORTS; k++)
        rdata_q[k] <= (gnt[k] && !s_we) ? mem[widx] : '0;
    end
  end

  // Responses are suppressed while reset is held so a pending one never escapes.
  assign bus.rvalid_o = rst_i ? '0 : rvalid_q;
  assign bus.rdata_o  = rst_i ? '0 : rdata_q;

  // Completion mirrors match the full byte address, not the folded index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_flag_o   <= '0;
      mem_result_o <= '0;
    end else begin
      if (s_wr && s_addr == FLAG_ADDR)
        mem_flag_o <= merge_be(mem_flag_o, s_wdata, s_be);
      if (s_wr && s_addr == RESULT_ADDR)
        mem_result_o <= merge_be(mem_result_o, s_wdata, s_be);
    end
  end

  // Saturating count of cycles with two or more simultaneous requests.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      conflict_cnt_o <= '0;
    else if ($countones(bus.req_i) >= 2 && conflict_cnt_o != 16'hFFFF)
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
  end

endmodule

// File: doc/soc_mem_arbiter_rr.md
Name: soc_mem_arbiter_rr

Overview:
N-port round-robin arbitrated shared data/instruction RAM for multi-core SoC builds. It generalises the fixed two-core dual-port RAM arrangement to NUM_PORTS cores sharing one single-port synchronous RAM. Each port uses the core-side req/gnt/rvalid memory protocol. The block also mirrors the completion flag and result words as registered outputs, so benches and top levels can observe program completion.

Parameters:
NUM_PORTS, 2, number of requesting core ports (>=1)
DATA_WIDTH, 32, word width; must be a multiple of 8
DEPTH_WORDS, 1024, RAM depth in words; power of two
FLAG_ADDR, 32'h0000_0FF8, byte address whose writes update mem_flag_o
RESULT_ADDR, 32'h0000_0FFC, byte address whose writes update mem_result_o

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  NUM_PORTS  per-port request; held high until granted
addr_i  in  NUM_PORTS x 32  per-port byte address
we_i  in  NUM_PORTS  per-port write enable
be_i  in  NUM_PORTS x DATA_WIDTH/8  per-port byte enables
wdata_i  in  NUM_PORTS x DATA_WIDTH  per-port write data
gnt_o  out  NUM_PORTS  one-hot-or-zero grant, same cycle as request
rvalid_o  out  NUM_PORTS  response valid, one cycle after grant
rdata_o  out  NUM_PORTS x DATA_WIDTH  read data, valid with rvalid_o
mem_flag_o  out  DATA_WIDTH  last value written to FLAG_ADDR
mem_result_o  out  DATA_WIDTH  last value written to RESULT_ADDR
conflict_cnt_o  out  16  saturating count of cycles with more than one req_i high

Behaviour:
- Reset (rst_i high at a clock edge): rvalid_o=0, rdata_o=0, mem_flag_o=0, mem_result_o=0, conflict_cnt_o=0, and the RR pointer is set so port 0 has highest priority. RAM contents are not cleared.
- Reset mid-transaction: any response pending for the next cycle is dropped, so no rvalid is returned. gnt_o is forced to 0 while rst_i=1.
- Arbitration is combinational.
  - Priority order is last_granted+1, last_granted+2, … with wrap modulo NUM_PORTS.
  - gnt_o has at most one bit set. It is set only when the matching req_i is set.
  - gnt_o is 0 when no requests are pending.
- The pointer updates to the granted index at the clock edge of a grant. It holds when there is no grant.
- Accesses:
  - A granted access executes at that clock edge.
  - RAM index = addr_i[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo the RAM size. addr_i[1:0] is ignored.
  - On a write, only bytes with be_i=1 are updated.
  - On a read, the word is returned the next cycle.
- Response:
  - rvalid_o[k]=1 exactly one cycle after gnt_o[k], for both reads and writes.
  - On a read, rdata_o[k] carries the RAM word. On a write, rdata_o[k] is 0.
  - rdata_o of non-responding ports is 0.
- Ordering: a write followed by a read of the same word on the next granted access returns the written data, regardless of which port did either access.
- Back-to-back: one port requesting continuously alone is granted every cycle, giving full throughput.
- Flag/result mirrors:
  - A granted write whose full address equals FLAG_ADDR (or RESULT_ADDR) also updates mem_flag_o (or mem_result_o) with byte-enable masking, visible the cycle after the grant.
  - The RAM word is written as well.
- conflict_cnt_o increments by 1 in each cycle where popcount(req_i)>=2. It saturates at 16'hFFFF.
- NUM_PORTS=1: the block degenerates to a direct connection. gnt_o=req_i, and the pointer is constant.

Decomposition:
- Package soc_mem_pkg: byte-enable width localparam, index-width function (clog2 of DEPTH_WORDS), default FLAG_ADDR/RESULT_ADDR constants.
- Sub-module rr_arbiter: parameter N; inputs clk_i, rst_i, req; outputs gnt (one-hot) and gnt_idx; contains the pointer register.
- The RAM array, response pipeline register, mirrors and counter live in soc_mem_arbiter_rr.

Test Plan:
1. Reset then idle: all outputs 0 and gnt_o=0 for 10 cycles.
2. Port 0 writes 32'hDEADBEEF to 0x10 with be=4'b1111, then reads 0x10 -> gnt same cycle; rvalid_o[0] one cycle later; rdata_o[0]=32'hDEADBEEF.
3. Both ports hold req_i for 6 cycles -> grants alternate 0,1,0,1,0,1; each port gets 3 rvalids; conflict_cnt_o=6.
4. Write 32'h0000_0001 to FLAG_ADDR and 32'd42 to RESULT_ADDR -> mem_flag_o=1 and mem_result_o=42, each one cycle after its grant. A partial write with be=4'b0010 and data 32'h0000_AB00 to RESULT_ADDR -> mem_result_o=32'h0000_AB2A.
5. Address wrap: write 32'h5A5A5A5A to 0x1010 (DEPTH_WORDS=1024), read 0x0010 -> 32'h5A5A5A5A.
6. Assert rst_i on the cycle after a read grant -> no rvalid_o pulse; after reset, port 0 wins a simultaneous 0/1 request.
